// File: rtl/sha_acc_pkg.sv
// rtl/sha_acc_pkg.sv - register map, command words and master states shared by the SHA256 accelerator and its job master
package sha_acc_pkg;

  localparam logic [4:0] ADDR_MSG_BASE  = 5'd0;
  localparam logic [4:0] ADDR_CTRL      = 5'd16;
  localparam logic [4:0] ADDR_STAT      = 5'd17;
  localparam logic [4:0] ADDR_HASH_BASE = 5'd0;

  localparam logic [31:0] CMD_START_VAL = 32'hffffffff;
  localparam logic [31:0] CMD_ACK_VAL   = 32'h0f0f0f0f;
  localparam logic [31:0] CMD_ABORT_VAL = 32'hff0000ff;
  localparam logic [31:0] STAT_DONE_VAL = 32'hffffffff;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, POLL, FETCH, ACK, ABORT, RESP
  } state_e;

endpackage

// File: rtl/sha_job_master_if.sv
// rtl/sha_job_master_if.sv - Avalon-MM bus between the job master and the SHA256 accelerator slave
interface sha_job_master_if;

  logic        avm_chipselect;
  logic [4:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_chipselect, avm_address, avm_write, avm_read, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_chipselect, avm_address, avm_write, avm_read, avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/sha_job_master_rd_pipe.sv
// rtl/sha_job_master_rd_pipe.sv - delays each issued read by the slave latency into a capture strobe and index
module sha_rd_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned IDX_W   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             cap_o,
  output logic [IDX_W-1:0] cap_idx_o
);

  logic [LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]   idx_q [LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= issue_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_o     = vld_q[LATENCY-1];
  assign cap_idx_o = idx_q[LATENCY-1];

endmodule

// File: rtl/sha_job_master.sv
// rtl/sha_job_master.sv - loads a 512-bit block into the SHA256 accelerator, polls for completion and returns the hash
module sha_job_master #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter logic [31:0] CMD_START    = sha_acc_pkg::CMD_START_VAL,
  parameter logic [31:0] CMD_ACK      = sha_acc_pkg::CMD_ACK_VAL,
  parameter logic [31:0] CMD_ABORT    = sha_acc_pkg::CMD_ABORT_VAL,
  parameter logic [31:0] STAT_DONE    = sha_acc_pkg::STAT_DONE_VAL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [511:0]     job_block_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [255:0]     res_hash_o,
  output logic             res_err_o,
  sha_job_master_if.master bus
);
  import sha_acc_pkg::*;

  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [511:0]    block_q, block_d;
  logic [255:0]    hash_q, hash_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic            cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic            cap_valid;
  logic [2:0]      cap_idx;

  sha_rd_pipe #(.LATENCY(READ_LATENCY), .IDX_W(3)) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue_i   (rd_q),
    .idx_i     (addr_q[2:0]),
    .cap_o     (cap_valid),
    .cap_idx_o (cap_idx)
  );

  // Bus strobes are computed one cycle ahead so every avm_* output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    hash_d      = hash_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    poll_cnt_d  = poll_cnt_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    case (state_q)
      IDLE: if (job_valid_i) begin
        block_d = job_block_i;
        hash_d  = '0;
        cnt_d   = '0;
        wr_d    = 1'b1;
        addr_d  = ADDR_MSG_BASE;
        wdata_d = job_block_i[31:0];
        state_d = LOAD;
      end
      LOAD: begin
        wr_d = 1'b1;
        if (cnt_q == 4'd15) begin
          addr_d  = ADDR_CTRL;
          wdata_d = CMD_START;
          state_d = START;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          addr_d  = ADDR_MSG_BASE + 5'(cnt_d);
          wdata_d = block_q[{cnt_d, 5'b0} +: 32];
        end
      end
      START: begin
        cnt_d      = '0;
        pend_d     = 1'b0;
        poll_cnt_d = '0;
        state_d    = POLL;
      end
      POLL: if (cap_valid) begin
        if (bus.avm_readdata == STAT_DONE) begin
          pend_d  = 1'b0;
          cnt_d   = '0;
          rd_d    = 1'b1;
          addr_d  = ADDR_HASH_BASE;
          state_d = FETCH;
        end else begin
          if (poll_cnt_q != PW'(POLL_TIMEOUT)) poll_cnt_d = poll_cnt_q + 1'b1;
          if (poll_cnt_d == PW'(POLL_TIMEOUT)) begin
            pend_d  = 1'b0;
            hash_d  = '0;
            wr_d    = 1'b1;
            addr_d  = ADDR_CTRL;
            wdata_d = CMD_ABORT;
            state_d = ABORT;
          end else begin
            rd_d   = 1'b1;
            addr_d = ADDR_STAT;
          end
        end
      end else if (!pend_q) begin
        // Two idle cycles after START let the slave register its control word.
        if (cnt_q == 4'd0) begin
          cnt_d = 4'd1;
        end else begin
          rd_d   = 1'b1;
          addr_d = ADDR_STAT;
          pend_d = 1'b1;
        end
      end
      FETCH: begin
        if (cnt_q < 4'd7) begin
          cnt_d  = cnt_q + 4'd1;
          rd_d   = 1'b1;
          addr_d = ADDR_HASH_BASE + 5'(cnt_d);
        end
        if (cap_valid) begin
          hash_d[{cap_idx, 5'b0} +: 32] = bus.avm_readdata;
          if (cap_idx == 3'd7) begin
            wr_d    = 1'b1;
            addr_d  = ADDR_CTRL;
            wdata_d = CMD_ACK;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        res_valid_d = 1'b1;
        res_err_d   = 1'b0;
        state_d     = RESP;
      end
      ABORT: begin
        res_valid_d = 1'b1;
        res_err_d   = 1'b1;
        state_d     = RESP;
      end
      RESP: if (res_ready_i) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cs_d = wr_d | rd_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      block_q     <= '0;
      hash_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      poll_cnt_q  <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      hash_q      <= hash_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      poll_cnt_q  <= poll_cnt_d;
      cs_q        <= cs_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
    end
  end

  assign job_ready_o        = (state_q == IDLE);
  assign res_valid_o        = res_valid_q;
  assign res_hash_o         = hash_q;
  assign res_err_o          = res_err_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write      = wr_q;
  assign bus.avm_read       = rd_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_sha_job_master.sv
// tb/tb_sha_job_master.sv - scoreboard bench for sha_job_master against a behavioural accelerator slave
module tb_sha_job_master;

  localparam int TO = 8;
  localparam logic [31:0] C_START = 32'hffffffff;
  localparam logic [31:0] C_ACK   = 32'h0f0f0f0f;
  localparam logic [31:0] C_ABORT = 32'hff0000ff;
  localparam logic [31:0] C_DONE  = 32'hffffffff;

  typedef struct packed { logic wr; logic [4:0] addr; logic [31:0] data; } bus_t;
  typedef struct packed { logic err; logic [255:0] hash; } res_t;

  bus_t exp_bus[$];
  res_t exp_res[$];
  bus_t mb;
  res_t mr;

  logic         clk = 0;
  logic         reset_n = 0;
  logic         job_valid = 0;
  logic [511:0] job_block = '0;
  logic         job_ready;
  logic         res_valid;
  logic         res_ready = 1;
  logic [255:0] res_hash;
  logic         res_err;
  logic [31:0]  rdata;

  logic [31:0]  slv_hash [8];
  int           slv_polls = 0;
  int           spoll;
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;

  sha_job_master_if bus();
  assign bus.avm_readdata = rdata;

  sha_job_master #(.READ_LATENCY(1), .POLL_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .job_valid_i (job_valid),
    .job_ready_o (job_ready),
    .job_block_i (job_block),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_hash_o  (res_hash),
    .res_err_o   (res_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural accelerator: registered read data, done after slv_polls status reads (0 = never).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= 32'hdeadbeef;
      spoll <= 0;
    end else begin
      rdata <= 32'hdeadbeef;
      if (bus.avm_write && bus.avm_address == 5'd16 && bus.avm_writedata == C_START) spoll <= 0;
      if (bus.avm_read) begin
        if (bus.avm_address == 5'd17) begin
          spoll <= spoll + 1;
          rdata <= (slv_polls != 0 && spoll + 1 >= slv_polls) ? C_DONE : 32'h0;
        end else if (bus.avm_address < 5'd8) begin
          rdata <= slv_hash[bus.avm_address[2:0]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cs_eq_strobe", bus.avm_chipselect, bus.avm_read | bus.avm_write);
      chk("rd_wr_exclusive", bus.avm_read & bus.avm_write, 0);
      if (bus.avm_read | bus.avm_write) begin
        chk("addr_range", bus.avm_address <= 5'd17, 1);
        chk("bus_expected", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) begin
          mb = exp_bus.pop_front();
          chk("bus_kind", bus.avm_write, mb.wr);
          chk("bus_addr", bus.avm_address, mb.addr);
          if (mb.wr) chk("bus_wdata", bus.avm_writedata, mb.data);
        end
      end
      if (res_valid && res_ready) begin
        chk("res_expected", exp_res.size() != 0, 1);
        if (exp_res.size() != 0) begin
          mr = exp_res.pop_front();
          chk("res_hash", res_hash, mr.hash);
          chk("res_err", res_err, mr.err);
        end
      end
    end
  end

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic rand_hash();
    for (int k = 0; k < 8; k++) slv_hash[k] = $urandom;
  endtask

  // Reference: the bus transcript and result a job must produce, derived from the job rules.
  task automatic prep_job(input logic [511:0] blk, input int polls);
    bus_t b;
    res_t r;
    bit   done;
    int   nrd;
    done = (polls != 0) && (polls <= TO);
    nrd  = done ? polls : TO;
    for (int i = 0; i < 16; i++) begin
      b = {1'b1, 5'(i), blk[32*i +: 32]};
      exp_bus.push_back(b);
    end
    b = {1'b1, 5'd16, C_START};
    exp_bus.push_back(b);
    for (int i = 0; i < nrd; i++) begin
      b = {1'b0, 5'd17, 32'h0};
      exp_bus.push_back(b);
    end
    if (done) begin
      for (int k = 0; k < 8; k++) begin
        b = {1'b0, 5'(k), 32'h0};
        exp_bus.push_back(b);
        r.hash[32*k +: 32] = slv_hash[k];
      end
      b = {1'b1, 5'd16, C_ACK};
      r.err = 1'b0;
    end else begin
      b = {1'b1, 5'd16, C_ABORT};
      r.hash = '0;
      r.err = 1'b1;
    end
    exp_bus.push_back(b);
    exp_res.push_back(r);
    slv_polls = polls;
  endtask

  task automatic present_job(input logic [511:0] blk, output int acc);
    bit got = 0;
    acc = -1;
    job_block = blk;
    job_valid = 1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (job_ready) begin
        got = 1;
        acc = cyc;
      end
    end
    chk("job_accept", got, 1);
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic wait_res(output int vc);
    bit got = 0;
    vc = -1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
        vc = cyc;
      end
    end
    chk("res_arrive", got, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] snap;
    int a, v;
    bit seen;

    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_hash", res_hash, 0);
    chk("rst_avm", {bus.avm_chipselect, bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata}, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    blk = '0;
    blk[31:0] = 32'h61626380;
    blk[511:480] = 32'h00000018;
    slv_hash[0] = 32'hba7816bf; slv_hash[1] = 32'h8f01cfea;
    slv_hash[2] = 32'h414140de; slv_hash[3] = 32'h5dae2223;
    slv_hash[4] = 32'hb00361a3; slv_hash[5] = 32'h96177a9c;
    slv_hash[6] = 32'hb410ff61; slv_hash[7] = 32'hf20015ad;
    prep_job(blk, 5);
    present_job(blk, a);
    wait_res(v);

    blk = rand_blk();
    rand_hash();
    prep_job(blk, 1);
    present_job(blk, a);
    wait_res(v);
    chk("latency_immediate", v - a, 32);

    blk = rand_blk();
    prep_job(blk, 0);
    present_job(blk, a);
    wait_res(v);

    res_ready = 0;
    blk = rand_blk();
    rand_hash();
    prep_job(blk, 3);
    present_job(blk, a);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk("bp_res_arrive", seen, 1);
    snap = res_hash;
    @(posedge clk); #1;
    blk = rand_blk();
    rand_hash();
    prep_job(blk, 2);
    job_block = blk;
    job_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid_held", res_valid, 1);
      chk("bp_hash_stable", res_hash, snap);
      chk("bp_job_ready_low", job_ready, 0);
    end
    @(posedge clk); #1;
    res_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_job_ready_after", job_ready, 1);
    chk("bp_valid_cleared", res_valid, 0);
    @(posedge clk); #1;
    job_valid = 0;
    wait_res(v);

    for (int j = 0; j < 6; j++) begin
      blk = rand_blk();
      rand_hash();
      prep_job(blk, $urandom_range(1, 10));
      present_job(blk, a);
      wait_res(v);
    end

    blk = rand_blk();
    rand_hash();
    prep_job(blk, 1);
    present_job(blk, a);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.avm_read && bus.avm_address == 5'd2;
    end
    chk("rst_fetch_reached", seen, 1);
    @(posedge clk); #1;
    reset_n = 0;
    #1;
    chk("midrst_avm", {bus.avm_chipselect, bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata}, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_job_ready", job_ready, 1);
    exp_bus.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    blk = rand_blk();
    rand_hash();
    prep_job(blk, 4);
    present_job(blk, a);
    wait_res(v);

    repeat (3) @(posedge clk);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
